// File: rtl/reorder_buffer.sv
// 8-entry circular reorder buffer: allocates ROB indices at issue, captures CDB
// results, retires in program order and squashes younger entries on a mispredict.
module reorder_buffer (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            alloc_in,
    input  logic [4:0]      alloc_rd_in,
    input  logic            alloc_is_branch_in,
    output logic            alloc_ready_out,
    output logic [2:0]      alloc_ix_out,
    input  logic            cdb_valid_in,
    input  logic [2:0]      cdb_ix_in,
    input  logic [31:0]     cdb_value_in,
    input  logic            cdb_mispredict_in,
    input  logic [31:0]     cdb_target_in,
    input  logic [2:0]      q1_ix_in,
    input  logic [2:0]      q2_ix_in,
    output logic            q1_done_out,
    output logic            q2_done_out,
    output logic [31:0]     q1_value_out,
    output logic [31:0]     q2_value_out,
    output logic            commit_we_out,
    output logic [4:0]      commit_wa_out,
    output logic [31:0]     commit_wd_out,
    output logic [2:0]      commit_rob_ix_out,
    output logic            flush_out,
    output logic [7:0][4:0] flush_addrs_out,
    output logic [31:0]     redirect_pc_out
);

    typedef enum logic {ST_RUN, ST_FLUSH} state_t;

    state_t           state;
    logic [7:0]       ent_valid;
    logic [7:0]       ent_done;
    logic [7:0]       ent_branch;
    logic [7:0]       ent_mp;
    logic [7:0][4:0]  ent_rd;
    logic [7:0][31:0] ent_value;
    logic [7:0][31:0] ent_target;
    logic [2:0]       head;
    logic [2:0]       tail;
    logic [3:0]       count;
    logic [31:0]      flush_pc;

    logic retire;
    logic retire_mp;
    logic alloc_fire;

    assign retire     = (state == ST_RUN) && ent_valid[head] && ent_done[head];
    // A mispredict flag only matters on a control-flow entry.
    assign retire_mp  = retire && ent_mp[head] && ent_branch[head];
    assign alloc_ready_out = (count < 4'd8) && (state == ST_RUN) && !retire_mp;
    assign alloc_fire = alloc_in && alloc_ready_out;
    assign alloc_ix_out = tail;

    assign q1_done_out  = ent_valid[q1_ix_in] && ent_done[q1_ix_in];
    assign q2_done_out  = ent_valid[q2_ix_in] && ent_done[q2_ix_in];
    assign q1_value_out = ent_value[q1_ix_in];
    assign q2_value_out = ent_value[q2_ix_in];

    assign flush_out       = (state == ST_FLUSH);
    assign redirect_pc_out = flush_pc;

    always_comb begin
        commit_we_out     = 1'b0;
        commit_wa_out     = '0;
        commit_wd_out     = '0;
        commit_rob_ix_out = '0;
        if (retire) begin
            commit_we_out     = (ent_rd[head] != 5'd0);
            commit_wa_out     = ent_rd[head];
            commit_wd_out     = ent_value[head];
            commit_rob_ix_out = head;
        end
    end

    always_comb begin
        flush_addrs_out = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            if (flush_out && ent_valid[k])
                flush_addrs_out[k] = ent_rd[k];
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state      <= ST_RUN;
            ent_valid  <= '0;
            ent_done   <= '0;
            ent_branch <= '0;
            ent_mp     <= '0;
            ent_rd     <= '0;
            ent_value  <= '0;
            ent_target <= '0;
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            flush_pc   <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (cdb_valid_in && ent_valid[cdb_ix_in]) begin
                        ent_done[cdb_ix_in]   <= 1'b1;
                        ent_value[cdb_ix_in]  <= cdb_value_in;
                        ent_mp[cdb_ix_in]     <= cdb_mispredict_in;
                        ent_target[cdb_ix_in] <= cdb_target_in;
                    end
                    if (alloc_fire) begin
                        ent_valid[tail]  <= 1'b1;
                        ent_done[tail]   <= 1'b0;
                        ent_mp[tail]     <= 1'b0;
                        ent_rd[tail]     <= alloc_rd_in;
                        ent_branch[tail] <= alloc_is_branch_in;
                        tail             <= tail + 3'd1;
                    end
                    // Retirement clears last so it wins over a late CDB write to the head.
                    if (retire) begin
                        ent_valid[head] <= 1'b0;
                        ent_done[head]  <= 1'b0;
                        ent_mp[head]    <= 1'b0;
                        ent_value[head] <= '0;
                        head            <= head + 3'd1;
                        if (retire_mp) begin
                            state    <= ST_FLUSH;
                            flush_pc <= ent_target[head];
                        end
                    end
                    if (alloc_fire && !retire)
                        count <= count + 4'd1;
                    else if (!alloc_fire && retire)
                        count <= count - 4'd1;
                end
                ST_FLUSH: begin
                    ent_valid <= '0;
                    ent_done  <= '0;
                    ent_mp    <= '0;
                    tail      <= head;
                    count     <= '0;
                    flush_pc  <= '0;
                    state     <= ST_RUN;
                end
                default: state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: an in-order queue model is checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_reorder_buffer;

    logic            clk_in = 1'b0;
    logic            rst_in = 1'b1;
    logic            alloc_in = 1'b0;
    logic [4:0]      alloc_rd_in = '0;
    logic            alloc_is_branch_in = 1'b0;
    logic            alloc_ready_out;
    logic [2:0]      alloc_ix_out;
    logic            cdb_valid_in = 1'b0;
    logic [2:0]      cdb_ix_in = '0;
    logic [31:0]     cdb_value_in = '0;
    logic            cdb_mispredict_in = 1'b0;
    logic [31:0]     cdb_target_in = '0;
    logic [2:0]      q1_ix_in = '0;
    logic [2:0]      q2_ix_in = '0;
    logic            q1_done_out, q2_done_out;
    logic [31:0]     q1_value_out, q2_value_out;
    logic            commit_we_out;
    logic [4:0]      commit_wa_out;
    logic [31:0]     commit_wd_out;
    logic [2:0]      commit_rob_ix_out;
    logic            flush_out;
    logic [7:0][4:0] flush_addrs_out;
    logic [31:0]     redirect_pc_out;

    reorder_buffer dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .alloc_in(alloc_in), .alloc_rd_in(alloc_rd_in), .alloc_is_branch_in(alloc_is_branch_in),
        .alloc_ready_out(alloc_ready_out), .alloc_ix_out(alloc_ix_out),
        .cdb_valid_in(cdb_valid_in), .cdb_ix_in(cdb_ix_in), .cdb_value_in(cdb_value_in),
        .cdb_mispredict_in(cdb_mispredict_in), .cdb_target_in(cdb_target_in),
        .q1_ix_in(q1_ix_in), .q2_ix_in(q2_ix_in),
        .q1_done_out(q1_done_out), .q2_done_out(q2_done_out),
        .q1_value_out(q1_value_out), .q2_value_out(q2_value_out),
        .commit_we_out(commit_we_out), .commit_wa_out(commit_wa_out),
        .commit_wd_out(commit_wd_out), .commit_rob_ix_out(commit_rob_ix_out),
        .flush_out(flush_out), .flush_addrs_out(flush_addrs_out),
        .redirect_pc_out(redirect_pc_out)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;
    bit run_chk = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: in-flight instructions in program order, oldest first.
    typedef struct {
        logic [2:0]  ix;
        logic [4:0]  rd;
        bit          br;
        bit          done;
        logic [31:0] val;
        bit          mp;
        logic [31:0] tgt;
    } ent_t;

    ent_t        mq[$];
    logic [2:0]  m_head = '0;
    logic [2:0]  m_tail = '0;
    bit          m_flush = 1'b0;
    logic [31:0] m_ftgt = '0;

    function automatic int m_find(input logic [2:0] ix);
        foreach (mq[i]) if (mq[i].ix == ix) return i;
        return -1;
    endfunction

    function automatic bit m_retire();
        return !m_flush && mq.size() > 0 && mq[0].done;
    endfunction

    function automatic bit m_ready();
        return !m_flush && mq.size() < 8 && !(m_retire() && mq[0].mp && mq[0].br);
    endfunction

    always @(posedge clk_in) begin : model_upd
        bit ret, rdy;
        int k;
        if (rst_in) begin
            mq.delete();
            m_head = '0; m_tail = '0; m_flush = 1'b0; m_ftgt = '0;
        end else if (m_flush) begin
            mq.delete();
            m_tail = m_head; m_flush = 1'b0; m_ftgt = '0;
        end else begin
            ret = m_retire();
            rdy = m_ready();
            if (cdb_valid_in) begin
                k = m_find(cdb_ix_in);
                if (k >= 0) begin
                    mq[k].done = 1'b1;
                    mq[k].val  = cdb_value_in;
                    mq[k].mp   = cdb_mispredict_in;
                    mq[k].tgt  = cdb_target_in;
                end
            end
            if (ret) begin
                if (mq[0].mp && mq[0].br) begin
                    m_flush = 1'b1;
                    m_ftgt  = mq[0].tgt;
                end
                m_head = mq[0].ix + 3'd1;
                void'(mq.pop_front());
            end
            if (alloc_in && rdy) begin
                mq.push_back('{ix: m_tail, rd: alloc_rd_in, br: alloc_is_branch_in,
                               done: 1'b0, val: 32'd0, mp: 1'b0, tgt: 32'd0});
                m_tail = m_tail + 3'd1;
            end
        end
    end

    always @(negedge clk_in) begin : compare
        ent_t h;
        logic [7:0][4:0] fa;
        int k;
        if (!rst_in && run_chk) begin
            chk("alloc_ready", alloc_ready_out, m_ready());
            chk("alloc_ix", alloc_ix_out, m_tail);
            if (m_retire()) begin
                h = mq[0];
                chk("commit_we", commit_we_out, (h.rd != 5'd0));
                chk("commit_wa", commit_wa_out, h.rd);
                chk("commit_wd", commit_wd_out, h.val);
                chk("commit_rob_ix", commit_rob_ix_out, h.ix);
            end else begin
                chk("commit_we", commit_we_out, 0);
                chk("commit_wa", commit_wa_out, 0);
                chk("commit_wd", commit_wd_out, 0);
                chk("commit_rob_ix", commit_rob_ix_out, 0);
            end
            chk("flush", flush_out, m_flush);
            chk("redirect_pc", redirect_pc_out, m_flush ? m_ftgt : 32'd0);
            fa = '0;
            if (m_flush) foreach (mq[i]) fa[mq[i].ix] = mq[i].rd;
            chk("flush_addrs", flush_addrs_out, fa);
            k = m_find(q1_ix_in);
            chk("q1_done", q1_done_out, (k >= 0) && mq[k].done);
            if (k >= 0 && mq[k].done) chk("q1_value", q1_value_out, mq[k].val);
            k = m_find(q2_ix_in);
            chk("q2_done", q2_done_out, (k >= 0) && mq[k].done);
            if (k >= 0 && mq[k].done) chk("q2_value", q2_value_out, mq[k].val);
        end
    end

    task automatic cyc();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_alloc(input logic [4:0] rd, input bit br);
        alloc_in = 1'b1; alloc_rd_in = rd; alloc_is_branch_in = br;
        cyc();
        alloc_in = 1'b0; alloc_rd_in = '0; alloc_is_branch_in = 1'b0;
    endtask

    task automatic do_cdb(input logic [2:0] ix, input logic [31:0] v, input bit mp, input logic [31:0] t);
        cdb_valid_in = 1'b1; cdb_ix_in = ix; cdb_value_in = v;
        cdb_mispredict_in = mp; cdb_target_in = t;
        cyc();
        cdb_valid_in = 1'b0; cdb_ix_in = '0; cdb_value_in = '0;
        cdb_mispredict_in = 1'b0; cdb_target_in = '0;
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        cyc(); cyc();
        rst_in = 1'b0;
    endtask

    initial begin : stim
        logic [7:0][4:0] exp_fa;

        do_reset();
        run_chk = 1'b1;
        chk("rst_ready", alloc_ready_out, 1);
        chk("rst_ix", alloc_ix_out, 0);
        chk("rst_we", commit_we_out, 0);
        chk("rst_wa", commit_wa_out, 0);
        chk("rst_wd", commit_wd_out, 0);
        chk("rst_rix", commit_rob_ix_out, 0);
        chk("rst_flush", flush_out, 0);
        chk("rst_faddrs", flush_addrs_out, 0);
        chk("rst_redirect", redirect_pc_out, 0);
        chk("rst_q1_done", q1_done_out, 0);
        chk("rst_q1_value", q1_value_out, 0);
        cyc(); cyc();

        // In-order retirement with out-of-order completion.
        do_alloc(5'd5, 1'b0);
        do_alloc(5'd6, 1'b0);
        do_alloc(5'd7, 1'b0);
        q1_ix_in = 3'd0;
        #1;
        chk("alloc_not_done", q1_done_out, 0);
        do_cdb(3'd1, 32'h22, 1'b0, 32'd0);
        chk("ix1_waits", commit_we_out, 0);
        do_cdb(3'd0, 32'h11, 1'b0, 32'd0);
        chk("c0_we", commit_we_out, 1);
        chk("c0_wa", commit_wa_out, 5);
        chk("c0_wd", commit_wd_out, 32'h11);
        chk("c0_rix", commit_rob_ix_out, 0);
        do_cdb(3'd2, 32'h33, 1'b0, 32'd0);
        chk("c1_wa", commit_wa_out, 6);
        chk("c1_wd", commit_wd_out, 32'h22);
        chk("c1_rix", commit_rob_ix_out, 1);
        cyc();
        chk("c2_wa", commit_wa_out, 7);
        chk("c2_wd", commit_wd_out, 32'h33);
        chk("c2_rix", commit_rob_ix_out, 2);
        cyc();
        chk("c3_idle_we", commit_we_out, 0);

        // Full buffer, ignored allocation, wrap of tail.
        do_reset();
        for (int i = 0; i < 8; i++) do_alloc(5'(10 + i), 1'b0);
        chk("full_ready", alloc_ready_out, 0);
        chk("full_ix", alloc_ix_out, 0);
        do_alloc(5'd31, 1'b0);
        chk("full_ignored_ix", alloc_ix_out, 0);
        do_cdb(3'd0, 32'hA0, 1'b0, 32'd0);
        chk("full_retire_we", commit_we_out, 1);
        chk("full_no_bypass", alloc_ready_out, 0);
        cyc();
        chk("unfull_ready", alloc_ready_out, 1);
        chk("unfull_ix_wrap", alloc_ix_out, 0);

        // rd=0 entry retires without a register write; head wraps.
        do_alloc(5'd0, 1'b0);
        for (int i = 1; i < 8; i++) do_cdb(3'(i), 32'hB0 + 32'(i), 1'b0, 32'd0);
        do_cdb(3'd0, 32'hFF, 1'b0, 32'd0);
        chk("rd0_we", commit_we_out, 0);
        chk("rd0_rix", commit_rob_ix_out, 0);
        chk("rd0_wd", commit_wd_out, 32'hFF);
        cyc();
        chk("rd0_idle_we", commit_we_out, 0);
        chk("rd0_head_adv_ix", alloc_ix_out, 1);

        // Retire and allocate in one cycle, then a mispredicted branch at ix2.
        do_alloc(5'd3, 1'b0);
        do_cdb(3'd1, 32'h5, 1'b0, 32'd0);
        chk("ra_retire_we", commit_we_out, 1);
        do_alloc(5'd1, 1'b1);
        chk("ra_ix", alloc_ix_out, 3);
        do_alloc(5'd8, 1'b0);
        do_alloc(5'd9, 1'b0);
        do_cdb(3'd2, 32'h104, 1'b1, 32'h400);
        chk("br_we", commit_we_out, 1);
        chk("br_wa", commit_wa_out, 1);
        chk("br_rix", commit_rob_ix_out, 2);
        chk("br_ready", alloc_ready_out, 0);
        do_alloc(5'd30, 1'b0);
        exp_fa = '0;
        exp_fa[3] = 5'd8;
        exp_fa[4] = 5'd9;
        chk("fl_flush", flush_out, 1);
        chk("fl_redirect", redirect_pc_out, 32'h400);
        chk("fl_addrs", flush_addrs_out, exp_fa);
        chk("fl_we", commit_we_out, 0);
        cyc();
        chk("post_fl_flush", flush_out, 0);
        chk("post_fl_ix", alloc_ix_out, 3);
        chk("post_fl_ready", alloc_ready_out, 1);

        // Forwarding lookups.
        do_alloc(5'd2, 1'b0);
        do_alloc(5'd4, 1'b0);
        q1_ix_in = 3'd4;
        q2_ix_in = 3'd6;
        do_cdb(3'd4, 32'hABCD, 1'b0, 32'd0);
        chk("fwd_done", q1_done_out, 1);
        chk("fwd_value", q1_value_out, 32'hABCD);
        chk("fwd_no_retire", commit_we_out, 0);
        do_cdb(3'd6, 32'h77, 1'b0, 32'd0);
        chk("fwd_unalloc", q2_done_out, 0);
        do_cdb(3'd3, 32'h3, 1'b0, 32'd0);
        cyc(); cyc();
        chk("drain_ix", alloc_ix_out, 5);

        // Reset during the flush cycle drops flush immediately.
        do_alloc(5'd0, 1'b1);
        do_cdb(3'd5, 32'd0, 1'b1, 32'h800);
        cyc();
        chk("rf_flush", flush_out, 1);
        #2 rst_in = 1'b1;
        #1;
        chk("rf_async_flush", flush_out, 0);
        chk("rf_async_redirect", redirect_pc_out, 0);
        cyc();
        rst_in = 1'b0;
        cyc(); cyc();
        chk("rf_ix", alloc_ix_out, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #200000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
